alu_seq_param: RTL and testbench

//   Parametrised, clocked successor of the 16-bit combinational ALU_struct_2.

---
 rtl/alu_seq_param.sv | 181 ++++++++++++++++++
 tb/tb_alu_seq_param.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_param.sv
// rtl/alu_seq_param.sv - clocked parametrised ALU with start/busy/done handshake and shift-add multiply
//
// Purpose: executes one operation per request on latched operands.
//   Opcodes 0-6 finish one edge after acceptance. Opcode 7 (MUL) runs a
//   shift-add loop over WIDTH edges. The result and flags are registered
//   and hold their value until the next write.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset
//   start - request, sampled only while idle
//   a, b  - operands (WIDTH bits)
//   cin   - carry-in, used by ADD only
//   opc   - operation select (0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 NOT,6 SHL,7 MUL)
//   busy  - operation in progress
//   done  - one-cycle pulse, w/flags just updated
//   w     - registered result
//   zero  - registered w == 0
//   neg   - registered w[WIDTH-1]
//   cout  - registered carry/overflow, meaning depends on opcode
module alu_seq_param #(
  parameter int WIDTH = 16,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [2:0]       opc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] w,
  output logic             zero,
  output logic             neg,
  output logic             cout
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_MUL} state_t;

  state_t               r_state;
  state_t               w_next_state;

  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;      // during MUL this is the multiplier, shifted right each edge
  logic                 r_cin;
  logic [2:0]           r_opc;
  logic [CNTW-1:0]      r_cnt;
  logic [2*WIDTH-1:0]   r_acc;    // partial product
  logic [2*WIDTH-1:0]   r_mcand;  // multiplicand, shifted left each edge

  logic [WIDTH-1:0]     r_w;
  logic                 r_zero;
  logic                 r_neg;
  logic                 r_cout;
  logic                 r_done;

  logic                 w_load;
  logic                 w_mul_last;
  logic [WIDTH:0]       w_add;
  logic [CNTW-2:0]      w_shamt;
  logic [WIDTH:0]       w_shl;
  logic [WIDTH-1:0]     w_res;
  logic                 w_res_c;
  logic [2*WIDTH-1:0]   w_prod;
  logic                 w_wr_en;
  logic [WIDTH-1:0]     w_wr_val;
  logic                 w_wr_c;

  assign w_load     = (r_state == S_IDLE) && start;
  assign w_mul_last = (r_state == S_MUL) && (r_cnt == CNTW'(WIDTH - 1));

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (start) w_next_state = (opc == 3'd7) ? S_MUL : S_RUN;
      S_RUN:  w_next_state = S_IDLE;
      S_MUL:  if (w_mul_last) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Single-cycle operations on the latched operands
  assign w_add   = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};
  assign w_shamt = r_b[CNTW-2:0];
  // Extra top bit catches the last bit shifted out; it stays 0 for a zero shift.
  assign w_shl   = {1'b0, r_a} << w_shamt;

  always_comb begin
    w_res   = '0;
    w_res_c = 1'b0;
    case (r_opc)
      3'd0: begin w_res = w_add[WIDTH-1:0]; w_res_c = w_add[WIDTH]; end
      3'd1: begin w_res = r_a - r_b;        w_res_c = (r_a >= r_b);  end
      3'd2: w_res = r_a & r_b;
      3'd3: w_res = r_a | r_b;
      3'd4: w_res = r_a ^ r_b;
      3'd5: w_res = ~r_a;
      3'd6: begin w_res = w_shl[WIDTH-1:0]; w_res_c = w_shl[WIDTH]; end
      default: begin w_res = '0; w_res_c = 1'b0; end
    endcase
  end

  // Shift-add step: add the multiplicand when the current multiplier LSB is set
  assign w_prod = r_acc + (r_b[0] ? r_mcand : '0);

  // Result write mux
  always_comb begin
    w_wr_en  = 1'b0;
    w_wr_val = '0;
    w_wr_c   = 1'b0;
    if (r_state == S_RUN) begin
      w_wr_en  = 1'b1;
      w_wr_val = w_res;
      w_wr_c   = w_res_c;
    end else if (w_mul_last) begin
      w_wr_en  = 1'b1;
      w_wr_val = w_prod[WIDTH-1:0];
      w_wr_c   = |w_prod[2*WIDTH-1:WIDTH];
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
      r_opc   <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mcand <= '0;
      r_w     <= '0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
      r_cout  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_wr_en;
      if (w_load) begin
        r_a     <= a;
        r_b     <= b;
        r_cin   <= cin;
        r_opc   <= opc;
        r_cnt   <= '0;
        r_acc   <= '0;
        r_mcand <= {{WIDTH{1'b0}}, a};
      end else if (r_state == S_MUL) begin
        r_acc   <= w_prod;
        r_mcand <= r_mcand << 1;
        r_b     <= r_b >> 1;
        r_cnt   <= r_cnt + CNTW'(1);
      end
      if (w_wr_en) begin
        r_w    <= w_wr_val;
        r_zero <= (w_wr_val == '0);
        r_neg  <= w_wr_val[WIDTH-1];
        r_cout <= w_wr_c;
      end
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign w    = r_w;
  assign zero = r_zero;
  assign neg  = r_neg;
  assign cout = r_cout;

endmodule

// File: tb/tb_alu_seq_param.sv
// tb/tb_alu_seq_param.sv - scoreboard bench for alu_seq_param with directed vectors
module tb_alu_seq_param;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [2:0]  opc;
  logic        busy;
  logic        done;
  logic [15:0] w;
  logic        zero;
  logic        neg;
  logic        cout;

  alu_seq_param #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .opc(opc),
    .busy(busy), .done(done), .w(w), .zero(zero), .neg(neg), .cout(cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ew;
    logic        ez;
    logic        en;
    logic        ec;
    int          ecyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done cyc=%0d w=%h (no result was expected)", cyc, w);
      end else begin
        mon_e = q.pop_front();
        if (w !== mon_e.ew || zero !== mon_e.ez || neg !== mon_e.en ||
            cout !== mon_e.ec || cyc != mon_e.ecyc) begin
          errors++;
          $display("FAIL result got w=%h z=%b n=%b c=%b cyc=%0d expected w=%h z=%b n=%b c=%b cyc=%0d",
                   w, zero, neg, cout, cyc, mon_e.ew, mon_e.ez, mon_e.en, mon_e.ec, mon_e.ecyc);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the sampling edge k.
  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic icin,
                       input logic [2:0] iop, input bit push,
                       input logic [15:0] ew, input logic ec);
    exp_t e;
    start = 1'b1;
    a     = ia;
    b     = ib;
    cin   = icin;
    opc   = iop;
    if (push) begin
      e.ew   = ew;
      e.ez   = (ew == 16'h0000);
      e.en   = ew[15];
      e.ec   = ec;
      e.ecyc = cyc + 1 + ((iop == 3'd7) ? 16 : 1);
      q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Leaves the bench at the negedge where done is visible (the done cycle).
  task automatic wait_done(input int lim);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < lim);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout waited=%0d done=%b required done=1", n, done);
    end
  endtask

  task automatic check_bit(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b expected=%b", nm, got, exp);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    opc   = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, w, zero, neg, cout} !== 21'd0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b w=%h z=%b n=%b c=%b expected all 0",
               busy, done, w, zero, neg, cout);
    end
    rst = 1'b0;
    @(negedge clk);

    // ADD wrap to zero, SUB with borrow
    issue(16'hFFFF, 16'h0001, 1'b0, 3'd0, 1, 16'h0000, 1'b1); wait_done(8);
    issue(16'h0005, 16'h0007, 1'b0, 3'd1, 1, 16'hFFFE, 1'b0); wait_done(8);

    // MUL 300*300 with an ignored start mid-operation, then ADD in done cycle
    issue(16'd300, 16'd300, 1'b0, 3'd7, 1, 16'h5F90, 1'b1);
    check_bit("mul_busy_k", busy, 1'b1);
    check_bit("mul_nodone_k", done, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      check_bit($sformatf("mul_busy_k%0d", i), busy, 1'b1);
      check_bit($sformatf("mul_nodone_k%0d", i), done, 1'b0);
      if (i == 4) begin
        start = 1'b1; a = 16'h0001; b = 16'h0001; opc = 3'd0;
      end else if (i == 5) begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    check_bit("mul_done_k16", done, 1'b1);
    check_bit("mul_idle_k16", busy, 1'b0);
    issue(16'h0002, 16'h0003, 1'b0, 3'd0, 1, 16'h0005, 1'b0); wait_done(8);

    // Remaining single-cycle opcodes, back to back from the done cycle
    issue(16'h0007, 16'h0008, 1'b1, 3'd0, 1, 16'h0010, 1'b0); wait_done(8);
    issue(16'h0007, 16'h0007, 1'b0, 3'd1, 1, 16'h0000, 1'b1); wait_done(8);
    issue(16'hF0F0, 16'hFF00, 1'b0, 3'd2, 1, 16'hF000, 1'b0); wait_done(8);
    issue(16'h00F0, 16'h0F00, 1'b0, 3'd3, 1, 16'h0FF0, 1'b0); wait_done(8);
    issue(16'hAAAA, 16'hAAAA, 1'b0, 3'd4, 1, 16'h0000, 1'b0); wait_done(8);
    issue(16'h0000, 16'h1234, 1'b1, 3'd5, 1, 16'hFFFF, 1'b0); wait_done(8);
    issue(16'h8001, 16'h0001, 1'b0, 3'd6, 1, 16'h0002, 1'b1); wait_done(8);
    issue(16'h8001, 16'h0000, 1'b0, 3'd6, 1, 16'h8001, 1'b0); wait_done(8);
    issue(16'h0003, 16'h000F, 1'b0, 3'd6, 1, 16'h8000, 1'b1); wait_done(8);
    issue(16'h4000, 16'h0011, 1'b0, 3'd6, 1, 16'h8000, 1'b0); wait_done(8);

    // MUL overflow and zero
    issue(16'hFFFF, 16'hFFFF, 1'b0, 3'd7, 1, 16'h0001, 1'b1); wait_done(40);
    issue(16'h0000, 16'h0005, 1'b0, 3'd7, 1, 16'h0000, 1'b0); wait_done(40);

    // Reset mid-multiply, then a clean MUL
    issue(16'h0003, 16'h0004, 1'b0, 3'd7, 0, 16'h0000, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, w, zero, neg, cout} !== 21'd0) begin
      errors++;
      $display("FAIL async_reset got busy=%b done=%b w=%h z=%b n=%b c=%b expected all 0",
               busy, done, w, zero, neg, cout);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(16'h0003, 16'h0004, 1'b0, 3'd7, 1, 16'h000C, 1'b0); wait_done(40);

    repeat (20) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL outstanding got=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
